// File: rtl/soc_evt_link_tx.sv
// soc_evt_link_tx: producer side of the SoC-to-cluster event link.
// NB_CH sources are arbitrated round-robin into a BUFFER_WIDTH-slot ring whose write
// pointer is exported as a Johnson-coded token; the cluster's read pointer comes back
// through a 2-flop synchroniser and throttles acceptance.
// Optional feature: define SOC_EVT_LINK_PRIO_EN to add evt_prio_i and restrict the
// grant to high-priority requesters whenever any of them is valid.
module soc_evt_link_tx #(
  parameter int unsigned NB_CH        = 4,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned BUFFER_WIDTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [NB_CH-1:0]                   evt_valid_i,
  input  logic [NB_CH*EVNT_WIDTH-1:0]        evt_data_i,
  output logic [NB_CH-1:0]                   evt_ready_o,
`ifdef SOC_EVT_LINK_PRIO_EN
  input  logic [NB_CH-1:0]                   evt_prio_i,
`endif
  output logic [BUFFER_WIDTH-1:0]            evt_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            evt_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] evt_da_o,
  output logic [$clog2(BUFFER_WIDTH):0]      level_o,
  output logic                               full_o
);

  // Positions span 0..2*BUFFER_WIDTH-1, which always fits in clog2(BUFFER_WIDTH)+1 bits.
  localparam int unsigned PosW = $clog2(BUFFER_WIDTH) + 1;
  localparam int unsigned ChW  = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam logic [PosW-1:0] RingSpan = PosW'(2 * BUFFER_WIDTH);
  localparam logic [PosW-1:0] Depth    = PosW'(BUFFER_WIDTH);

  // Johnson code -> position; non-Johnson codes go through the same formula unchecked.
  function automatic logic [PosW-1:0] jc_decode(input logic [BUFFER_WIDTH-1:0] code);
    logic [PosW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
      cnt = cnt + PosW'(code[i]);
    end
    if (code[BUFFER_WIDTH-1]) begin
      jc_decode = RingSpan - cnt;
    end else begin
      jc_decode = cnt;
    end
  endfunction

  logic [BUFFER_WIDTH-1:0]            wt_q, wt_d;
  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] da_q, da_d;
  logic [BUFFER_WIDTH-1:0]            rp_meta_q, rp_sync_q;
  // Channel where the next round-robin search begins (one past the last grant).
  logic [ChW-1:0]                     rr_q, rr_d;

  logic [PosW-1:0]       w_pos, rp_pos, w_slot, level;
  logic                  full;
  logic [NB_CH-1:0]      cand;
  logic                  gnt_any;
  logic [ChW-1:0]        gnt_idx;
  logic                  xfer;
  logic [EVNT_WIDTH-1:0] wdata;

  // Occupancy from the registered write token and the synchronised read pointer.
  always_comb begin
    w_pos  = jc_decode(wt_q);
    rp_pos = jc_decode(rp_sync_q);
    if (w_pos >= rp_pos) begin
      level = w_pos - rp_pos;
    end else begin
      level = w_pos + RingSpan - rp_pos;
    end
    w_slot = (w_pos >= Depth) ? (w_pos - Depth) : w_pos;
    full   = (level == Depth);
  end

  // Round-robin grant over the candidate set, starting at rr_q.
  always_comb begin
`ifdef SOC_EVT_LINK_PRIO_EN
    if (|(evt_valid_i & evt_prio_i)) begin
      cand = evt_valid_i & evt_prio_i;
    end else begin
      cand = evt_valid_i;
    end
`else
    cand = evt_valid_i;
`endif
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NB_CH; i++) begin
      int unsigned c;
      c = 32'(rr_q) + i;
      if (c >= NB_CH) begin
        c = c - NB_CH;
      end
      if (!gnt_any && cand[c]) begin
        gnt_any = 1'b1;
        gnt_idx = ChW'(c);
      end
    end
  end

  // Handshake and selection of the granted channel's event ID.
  always_comb begin
    xfer        = gnt_any & ~full;
    evt_ready_o = '0;
    if (xfer) begin
      evt_ready_o[gnt_idx] = 1'b1;
    end
    wdata = '0;
    for (int unsigned c = 0; c < NB_CH; c++) begin
      if (ChW'(c) == gnt_idx) begin
        wdata = evt_data_i[c*EVNT_WIDTH +: EVNT_WIDTH];
      end
    end
  end

  // Next state: on a transfer write the slot, step the token, move the RR start.
  always_comb begin
    wt_d = wt_q;
    da_d = da_q;
    rr_d = rr_q;
    if (xfer) begin
      wt_d = {wt_q[BUFFER_WIDTH-2:0], ~wt_q[BUFFER_WIDTH-1]};
      for (int unsigned s = 0; s < BUFFER_WIDTH; s++) begin
        if (w_slot == PosW'(s)) begin
          da_d[s*EVNT_WIDTH +: EVNT_WIDTH] = wdata;
        end
      end
      rr_d = (gnt_idx == ChW'(NB_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Ring, token, RR pointer and read-pointer synchroniser state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wt_q      <= '0;
      da_q      <= '0;
      rr_q      <= '0;
      rp_meta_q <= '0;
      rp_sync_q <= '0;
    end else begin
      wt_q      <= wt_d;
      da_q      <= da_d;
      rr_q      <= rr_d;
      rp_meta_q <= evt_rp_i;
      rp_sync_q <= rp_meta_q;
    end
  end

  assign evt_wt_o = wt_q;
  assign evt_da_o = da_q;
  assign level_o  = level;
  assign full_o   = full;

endmodule

// File: tb/tb_soc_evt_link_tx.sv
// Directed bench for soc_evt_link_tx with a position-level reference model.
`timescale 1ns/1ps
module tb_soc_evt_link_tx;
  localparam int NB_CH = 4;
  localparam int EW    = 8;
  localparam int BW    = 8;
  localparam int SPAN  = 2 * BW;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NB_CH-1:0]      evt_valid, evt_ready;
  logic [NB_CH*EW-1:0]   evt_data;
`ifdef SOC_EVT_LINK_PRIO_EN
  logic [NB_CH-1:0]      evt_prio;
  logic [NB_CH-1:0]      src_prio;
`endif
  logic [BW-1:0]         evt_wt, evt_rp;
  logic [BW*EW-1:0]      evt_da;
  logic [$clog2(BW):0]   level;
  logic                  full;

  soc_evt_link_tx #(.NB_CH(NB_CH), .EVNT_WIDTH(EW), .BUFFER_WIDTH(BW)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .evt_valid_i (evt_valid),
    .evt_data_i  (evt_data),
    .evt_ready_o (evt_ready),
`ifdef SOC_EVT_LINK_PRIO_EN
    .evt_prio_i  (evt_prio),
`endif
    .evt_wt_o    (evt_wt),
    .evt_rp_i    (evt_rp),
    .evt_da_o    (evt_da),
    .level_o     (level),
    .full_o      (full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sources
  int            src_left [NB_CH];
  int            src_cnt  [NB_CH];
  logic [EW-1:0] src_base [NB_CH];

  // Model state: write position, ring image, rp synchroniser codes, last grant.
  int            m_w;
  int            m_last;
  logic [EW-1:0] m_slot [BW];
  logic [BW-1:0] m_rp1, m_rp2;
  logic [EW-1:0] sb [$];
  int            grant_log [$];

  // Consumer
  int cons_budget = 0;
  int cons_count  = 0;
  int rp_pos      = 0;

  // Monitors
  bit            mon_en = 1'b0;
  bit            mon_wrap = 1'b0;
  int            mon_max = 0;
  logic [BW-1:0] prev_wt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] jenc(input int p);
    logic [BW-1:0] ones;
    ones = '1;
    if (p <= BW) return BW'((1 << p) - 1);
    return ones << (p - BW);
  endfunction

  function automatic int jdec(input logic [BW-1:0] c);
    int n;
    n = $countones(c);
    return c[BW-1] ? SPAN - n : n;
  endfunction

  function automatic int m_level();
    return (m_w - jdec(m_rp2) + SPAN) % SPAN;
  endfunction

  function automatic int m_grant(input logic [NB_CH-1:0] v);
    logic [NB_CH-1:0] cand;
    cand = v;
`ifdef SOC_EVT_LINK_PRIO_EN
    if ((v & evt_prio) != '0) cand = v & evt_prio;
`endif
    for (int k = 1; k <= NB_CH; k++) begin
      int c;
      c = (m_last + k) % NB_CH;
      if (cand[c]) return c;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_w    = 0;
    m_last = -1;
    for (int s = 0; s < BW; s++) m_slot[s] = '0;
    m_rp1 = '0;
    m_rp2 = '0;
    sb.delete();
  endfunction

  // Reference model: advances on each clock edge from the rules of the link.
  initial begin
    int            g;
    bit            fl;
    logic [EW-1:0] d;
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_reset();
      end else begin
        fl = (m_level() == BW);
        g  = m_grant(evt_valid);
        if (g >= 0 && !fl) begin
          d = evt_data[g*EW +: EW];
          m_slot[m_w % BW] = d;
          m_w    = (m_w + 1) % SPAN;
          m_last = g;
          sb.push_back(d);
        end
        m_rp2 = m_rp1;
        m_rp1 = evt_rp;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    int               g;
    logic [NB_CH-1:0] er;
    logic [BW*EW-1:0] eda;
    forever begin
      @(negedge clk);
      g  = m_grant(evt_valid);
      er = '0;
      if (g >= 0 && m_level() != BW) er[g] = 1'b1;
      for (int s = 0; s < BW; s++) eda[s*EW +: EW] = m_slot[s];
      check("ready", 64'(evt_ready), 64'(er));
      check("wt", 64'(evt_wt), 64'(jenc(m_w)));
      check("da", 64'(evt_da), 64'(eda));
      check("level", 64'(level), 64'(m_level()));
      check("full", 64'(full), 64'(m_level() == BW));
      if (rstn && (evt_valid & evt_ready) != '0) begin
        for (int c = 0; c < NB_CH; c++) if (evt_ready[c]) grant_log.push_back(c);
      end
      if (mon_en) begin
        if (prev_wt == 8'h80 && evt_wt == 8'h00) mon_wrap = 1'b1;
        if (int'(level) > mon_max) mon_max = int'(level);
      end
      prev_wt = evt_wt;
    end
  end

  // Sources: hold valid/data until accepted, then present the next ID.
  initial begin
    logic [NB_CH-1:0] xf;
    evt_valid = '0;
    evt_data  = '0;
`ifdef SOC_EVT_LINK_PRIO_EN
    evt_prio  = '0;
`endif
    forever begin
      @(negedge clk);
      xf = evt_valid & evt_ready & {NB_CH{rstn}};
      @(posedge clk);
      #1;
      for (int c = 0; c < NB_CH; c++) begin
        if (xf[c] && src_left[c] > 0) begin
          src_left[c]--;
          src_cnt[c]++;
        end
        evt_valid[c]          = (src_left[c] > 0);
        evt_data[c*EW +: EW]  = src_base[c] + EW'(src_cnt[c]);
      end
`ifdef SOC_EVT_LINK_PRIO_EN
      evt_prio = src_prio;
`endif
    end
  end

  // Consumer: reads the slot at its read pointer, checks order, advances the pointer.
  initial begin
    evt_rp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        rp_pos = 0;
        evt_rp = '0;
      end else if (cons_budget > 0 && sb.size() > 0) begin
        check("sb_order", 64'(evt_da[(rp_pos % BW)*EW +: EW]), 64'(sb[0]));
        void'(sb.pop_front());
        cons_budget--;
        cons_count++;
        rp_pos = (rp_pos + 1) % SPAN;
        evt_rp = jenc(rp_pos);
      end
    end
  end

  task automatic do_reset();
    cons_budget = 0;
    for (int c = 0; c < NB_CH; c++) begin
      src_left[c] = 0;
      src_cnt[c]  = 0;
      src_base[c] = '0;
    end
`ifdef SOC_EVT_LINK_PRIO_EN
    src_prio = '0;
`endif
    @(posedge clk);
    #3 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    grant_log.delete();
    cons_count = 0;
  endtask

  task automatic wait_grants(input int n, input string name);
    int t;
    t = 0;
    while (grant_log.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(grant_log.size() >= n), 64'(1));
  endtask

  initial begin
    int n;
    int maxw;
    int lastpos [NB_CH];
    int exp_p [12];
    for (int c = 0; c < NB_CH; c++) begin
      src_left[c] = 0;
      src_cnt[c]  = 0;
      src_base[c] = '0;
    end
`ifdef SOC_EVT_LINK_PRIO_EN
    src_prio = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wt", 64'(evt_wt), 64'h0);
    check("rst_da", 64'(evt_da), 64'h0);
    check("rst_level", 64'(level), 64'h0);
    check("rst_full", 64'(full), 64'h0);
    @(posedge clk);
    #2 rstn = 1'b1;

    // Single event on ch2
    src_base[2] = 8'h5A;
    src_left[2] = 1;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("single_ready", 64'(evt_ready), 64'h4);
    @(posedge clk);
    #2;
    check("single_slot0", 64'(evt_da[7:0]), 64'h5A);
    check("single_wt", 64'(evt_wt), 64'h01);
    check("single_level", 64'(level), 64'h1);

    // Fill to full from ch0, rp held at 0
    do_reset();
    src_base[0] = 8'h10;
    src_left[0] = 9;
    n = 0;
    while (!full && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("fill_full", 64'(full), 64'h1);
    check("fill_ready", 64'(evt_ready), 64'h0);
    check("fill_wt", 64'(evt_wt), 64'hFF);
    check("fill_da", 64'(evt_da), 64'h1716151413121110);
    check("fill_level", 64'(level), 64'h8);
    check("fill_accepts", 64'(9 - src_left[0]), 64'h8);

    // Drain one slot: full falls two edges after rp moves
    @(posedge clk);
    #2 cons_budget = 1;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("drain_full_c0", 64'(full), 64'h1);
    @(negedge clk);
    check("drain_full_c1", 64'(full), 64'h1);
    @(negedge clk);
    check("drain_full_c2", 64'(full), 64'h0);
    check("drain_ready", 64'(evt_ready), 64'h1);
    @(posedge clk);
    #2;
    check("drain_slot0", 64'(evt_da[7:0]), 64'h18);
    check("drain_wt", 64'(evt_wt), 64'hFE);

    // Round-robin fairness, all channels valid
    do_reset();
    cons_budget = 1000;
    for (int c = 0; c < NB_CH; c++) begin
      src_base[c] = EW'(c * 32);
      src_left[c] = 5;
    end
    wait_grants(20, "rr_timeout");
    for (int i = 0; i < 20; i++) begin
      check("rr_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(i % 4));
    end
    maxw = 0;
    for (int c = 0; c < NB_CH; c++) lastpos[c] = -1;
    for (int i = 0; i < grant_log.size(); i++) begin
      if (lastpos[grant_log[i]] >= 0 && i - lastpos[grant_log[i]] - 1 > maxw) begin
        maxw = i - lastpos[grant_log[i]] - 1;
      end
      lastpos[grant_log[i]] = i;
    end
    check("rr_max_wait", 64'(maxw), 64'h3);

    // Wrap-around: 40 events with a tracking consumer
    do_reset();
    cons_budget = 1000;
    mon_wrap = 1'b0;
    mon_max  = 0;
    mon_en   = 1'b1;
    src_base[1] = 8'h80;
    src_left[1] = 40;
    n = 0;
    while ((src_left[1] != 0 || sb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap_done", 64'(src_left[1]), 64'h0);
    check("wrap_seen", 64'(mon_wrap), 64'h1);
    check("wrap_max_level", 64'(mon_max <= 8), 64'h1);
    check("wrap_consumed", 64'(cons_count), 64'd40);
    check("wrap_wt", 64'(evt_wt), 64'hFF);
    check("wrap_level", 64'(level), 64'h0);

`ifdef SOC_EVT_LINK_PRIO_EN
    // Priority class first, then the rest, single shared RR pointer
    do_reset();
    cons_budget = 1000;
    src_prio = 4'b1010;
    for (int c = 0; c < NB_CH; c++) begin
      src_base[c] = EW'(c * 32);
      src_left[c] = 3;
    end
    exp_p = '{1, 3, 1, 3, 1, 3, 0, 2, 0, 2, 0, 2};
    wait_grants(12, "prio_timeout");
    for (int i = 0; i < 12; i++) begin
      check("prio_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(exp_p[i]));
    end
`else
    exp_p = '{default: 0};
`endif

    // Reset in the middle of a stream clears everything at once
    do_reset();
    cons_budget = 1000;
    for (int c = 0; c < NB_CH; c++) begin
      src_base[c] = EW'(c * 16);
      src_left[c] = 10;
    end
    repeat (6) @(posedge clk);
    #3;
    check("mid_wt_moving", 64'(evt_wt != '0), 64'h1);
    cons_budget = 0;
    for (int c = 0; c < NB_CH; c++) src_left[c] = 0;
    rstn = 1'b0;
    #1;
    check("mid_rst_wt", 64'(evt_wt), 64'h0);
    check("mid_rst_level", 64'(level), 64'h0);
    check("mid_rst_full", 64'(full), 64'h0);
    check("mid_rst_da", 64'(evt_da), 64'h0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
